axi4_wch_order_arbiter: RTL and testbench
=========================================

# axi4_wch_order_arbiter

- Shares one master AXI4 W channel between N_PORTS slave W channels.
- Forwards write bursts strictly in the order the upstream AW arbiter granted them.
- Accepts and discards the data of bursts whose address was dropped (translation miss/protection fault), so no slave port stalls.
- Sits between the per-port W senders and the master W port of the RAB; the AW arbiter pushes one grant per accepted or dropped address.

## Interface
- N_PORTS, 2: number of slave W ports
- LOG_N_PORTS, 1: width of port index
- C_AXI_DATA_WIDTH, 32: W data width
- C_AXI_USER_WIDTH, 2: W user width
- ORDER_DEPTH, 8: grant-order FIFO entries
- LOG_ORDER_DEPTH, 3: log2(ORDER_DEPTH)

- axi4_aclk  in  1  clock, all logic on rising edge
- axi4_arstn  in  1  asynchronous active-low reset
- grant_valid  in  1  AW arbiter pushes a burst grant
- grant_port  in  LOG_N_PORTS  slave port owning the burst
- grant_drop  in  1  burst data must be discarded
- grant_ready  out  1  order FIFO can accept a grant
- s_axi4_wdata  in  N_PORTS*C_AXI_DATA_WIDTH  per-port data, port i at slice i
- s_axi4_wstrb  in  N_PORTS*C_AXI_DATA_WIDTH/8  per-port strobes
- s_axi4_wuser  in  N_PORTS*C_AXI_USER_WIDTH  per-port user
- s_axi4_wlast  in  N_PORTS  per-port last
- s_axi4_wvalid  in  N_PORTS  per-port valid
- s_axi4_wready  out  N_PORTS  per-port ready
- m_axi4_wdata  out  C_AXI_DATA_WIDTH  master data
- m_axi4_wstrb  out  C_AXI_DATA_WIDTH/8  master strobes
- m_axi4_wuser  out  C_AXI_USER_WIDTH  master user
- m_axi4_wlast  out  1  master last
- m_axi4_wvalid  out  1  master valid
- m_axi4_wready  in  1  master ready
- burst_done  out  1  one-cycle pulse when a burst's wlast beat completes
- burst_done_port  out  LOG_N_PORTS  port of completed burst
- burst_done_drop  out  1  completed burst was dropped
- order_count  out  LOG_ORDER_DEPTH+1  FIFO occupancy

## Operation
- Order FIFO:
  - Entries {drop, port}; push on grant_valid & grant_ready.
  - grant_port >= N_PORTS is stored with drop=1.
  - grant_ready = (order_count < ORDER_DEPTH), computed from registered count only; no full bypass, even with a same-cycle pop.
  - Push and pop in the same cycle: count unchanged.
- FSM states IDLE, FWD, DROP; current entry {cur_port, cur_drop} held in registers.
  - IDLE: if FIFO non-empty, pop the head, load cur_*, go to FWD (drop=0) or DROP (drop=1). Otherwise stay.
  - FWD:
    - m_axi4_wvalid = s_axi4_wvalid[cur_port].
    - s_axi4_wready[cur_port] = m_axi4_wready.
    - m_axi4_wdata/wstrb/wuser/wlast muxed from cur_port.
    - Completion on a handshake beat with wlast=1.
  - DROP:
    - s_axi4_wready[cur_port] = 1; m_axi4_wvalid = 0.
    - Completion on s_axi4_wvalid[cur_port] & s_axi4_wlast[cur_port].
  - On completion:
    - burst_done is registered and pulses in the next cycle with the completed port/drop.
    - If the FIFO is non-empty, pop the next entry and enter FWD/DROP directly (back-to-back, no bubble). Otherwise go to IDLE.
- Non-selected ports: s_axi4_wready = 0; beats arriving before their grant are held off.
- Outside FWD:
  - m_axi4_wvalid = 0.
  - m_axi4_wdata, m_axi4_wstrb, m_axi4_wuser and m_axi4_wlast are all zero.
- Once wvalid is asserted in FWD it is not withdrawn by the arbiter; selection changes only after wlast completion.

## Timing
- Reset (async assert, sync release):
  - FSM in IDLE; FIFO empty; order_count=0; grant_ready=1.
  - All s_axi4_wready=0; m_axi4_wvalid=0; all master data fields 0.
  - burst_done=0, burst_done_port=0, burst_done_drop=0.
- Reset mid-burst: burst and all queued grants are lost, with no completion pulse.
- Grant accepted in cycle T into an empty FIFO: entry visible in T+1, state FWD/DROP in T+2. First master beat possible at T+2 (combinational pass-through from the slave).
- Forwarding adds zero cycles per beat: 1 beat/cycle throughput when m_axi4_wready=1.
- Back-to-back bursts: the last beat of burst k at cycle C, first beat of burst k+1 possible at C+1.
- burst_done asserted in the cycle after the completing beat, for exactly one cycle.

## Test plan
- Single grant port 0, 4-beat burst, m_axi4_wready=1:
  - Beats appear on master at T+2..T+5 with matching data/strb/user.
  - wlast only on beat 4.
  - burst_done=1, port=0, drop=0 at T+6.
- Grants port1 then port0; port0 presents its burst first:
  - port0 wready stays 0 until port1's 2-beat burst completes.
  - port0's first beat then forwards in the next cycle, no gap.
- Drop grant on port 1, 3 beats, m_axi4_wready=0 throughout:
  - s_axi4_wready[1]=1 every beat; m_axi4_wvalid never 1.
  - burst_done_drop=1 after beat 3.
- Fill FIFO with 8 grants while the first burst is stalled by m_axi4_wready=0:
  - grant_ready=0 with order_count=8; a ninth grant is not accepted.
  - grant_ready returns 1 the cycle after the first completion.
- grant_port=3 with N_PORTS=2: entry treated as drop; completion reports drop=1.
- Assert axi4_arstn mid-burst:
  - Outputs go to reset values immediately, order_count=0.
  - The remaining beats are ignored until a new grant.

Source files
------------

// File: rtl/axi4_wch_order_arbiter.sv
// Shares one master AXI4 W channel between N_PORTS slave W channels, forwarding bursts in
// AW grant order and swallowing the data of dropped bursts.
module axi4_wch_order_arbiter #(
    parameter int unsigned N_PORTS          = 2,
    parameter int unsigned LOG_N_PORTS      = 1,
    parameter int unsigned C_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_AXI_USER_WIDTH = 2,
    parameter int unsigned ORDER_DEPTH      = 8,
    parameter int unsigned LOG_ORDER_DEPTH  = 3
) (
    input  logic                                   axi4_aclk,
    input  logic                                   axi4_arstn,
    input  logic                                   grant_valid,
    input  logic [LOG_N_PORTS-1:0]                 grant_port,
    input  logic                                   grant_drop,
    output logic                                   grant_ready,
    input  logic [N_PORTS*C_AXI_DATA_WIDTH-1:0]    s_axi4_wdata,
    input  logic [N_PORTS*C_AXI_DATA_WIDTH/8-1:0]  s_axi4_wstrb,
    input  logic [N_PORTS*C_AXI_USER_WIDTH-1:0]    s_axi4_wuser,
    input  logic [N_PORTS-1:0]                     s_axi4_wlast,
    input  logic [N_PORTS-1:0]                     s_axi4_wvalid,
    output logic [N_PORTS-1:0]                     s_axi4_wready,
    output logic [C_AXI_DATA_WIDTH-1:0]            m_axi4_wdata,
    output logic [C_AXI_DATA_WIDTH/8-1:0]          m_axi4_wstrb,
    output logic [C_AXI_USER_WIDTH-1:0]            m_axi4_wuser,
    output logic                                   m_axi4_wlast,
    output logic                                   m_axi4_wvalid,
    input  logic                                   m_axi4_wready,
    output logic                                   burst_done,
    output logic [LOG_N_PORTS-1:0]                 burst_done_port,
    output logic                                   burst_done_drop,
    output logic [LOG_ORDER_DEPTH:0]               order_count
);

    localparam int unsigned STRB_WIDTH = C_AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {StIdle, StFwd, StDrop} state_e;

    state_e                     state_q;
    logic [LOG_N_PORTS-1:0]     cur_port_q;
    logic                       cur_drop_q;
    logic                       done_q;
    logic [LOG_N_PORTS-1:0]     done_port_q;
    logic                       done_drop_q;

    // Order FIFO entry layout: {drop, port}
    logic [LOG_N_PORTS:0]       fifo_q [ORDER_DEPTH];
    logic [LOG_ORDER_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [LOG_ORDER_DEPTH:0]   count_q;

    logic push, pop, fifo_empty, grant_bad, cur_bad;
    logic sel_valid, sel_last, complete;
    logic [LOG_N_PORTS:0] head;

    assign grant_ready = count_q < (LOG_ORDER_DEPTH + 1)'(ORDER_DEPTH);
    assign fifo_empty  = (count_q == '0);
    assign push        = grant_valid & grant_ready;
    assign head        = fifo_q[rd_ptr_q];
    assign grant_bad   = 32'(grant_port) >= N_PORTS;
    assign cur_bad     = 32'(cur_port_q) >= N_PORTS;
    assign pop         = ~fifo_empty & ((state_q == StIdle) | complete);

    always_comb begin
        m_axi4_wdata  = '0;
        m_axi4_wstrb  = '0;
        m_axi4_wuser  = '0;
        m_axi4_wlast  = 1'b0;
        m_axi4_wvalid = 1'b0;
        s_axi4_wready = '0;
        sel_valid     = 1'b0;
        sel_last      = 1'b0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (cur_port_q == LOG_N_PORTS'(i)) begin
                sel_valid = s_axi4_wvalid[i];
                sel_last  = s_axi4_wlast[i];
                if (state_q == StFwd) begin
                    m_axi4_wdata     = s_axi4_wdata[i*C_AXI_DATA_WIDTH +: C_AXI_DATA_WIDTH];
                    m_axi4_wstrb     = s_axi4_wstrb[i*STRB_WIDTH +: STRB_WIDTH];
                    m_axi4_wuser     = s_axi4_wuser[i*C_AXI_USER_WIDTH +: C_AXI_USER_WIDTH];
                    m_axi4_wlast     = s_axi4_wlast[i];
                    m_axi4_wvalid    = s_axi4_wvalid[i];
                    s_axi4_wready[i] = m_axi4_wready;
                end else if (state_q == StDrop) begin
                    s_axi4_wready[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        unique case (state_q)
            StFwd:   complete = sel_valid & sel_last & m_axi4_wready;
            // No sender exists behind an out-of-range port, so its burst retires at once.
            StDrop:  complete = cur_bad | (sel_valid & sel_last);
            default: complete = 1'b0;
        endcase
    end

    always_ff @(posedge axi4_aclk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {grant_drop | grant_bad, grant_port};
        end
    end

    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + LOG_ORDER_DEPTH'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + LOG_ORDER_DEPTH'(1);
            if (push && !pop) begin
                count_q <= count_q + (LOG_ORDER_DEPTH + 1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (LOG_ORDER_DEPTH + 1)'(1);
            end
        end
    end

    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            state_q     <= StIdle;
            cur_port_q  <= '0;
            cur_drop_q  <= 1'b0;
            done_q      <= 1'b0;
            done_port_q <= '0;
            done_drop_q <= 1'b0;
        end else begin
            done_q <= complete;
            if (complete) begin
                done_port_q <= cur_port_q;
                done_drop_q <= cur_drop_q;
            end
            if (pop) begin
                cur_port_q <= head[LOG_N_PORTS-1:0];
                cur_drop_q <= head[LOG_N_PORTS];
                state_q    <= head[LOG_N_PORTS] ? StDrop : StFwd;
            end else if (complete) begin
                state_q <= StIdle;
            end
        end
    end

    assign burst_done      = done_q;
    assign burst_done_port = done_port_q;
    assign burst_done_drop = done_drop_q;
    assign order_count     = count_q;

endmodule

// File: tb/tb_axi4_wch_order_arbiter.sv
// Self-checking bench for axi4_wch_order_arbiter: directed scenarios plus a randomized run
// checked against a grant-order queue model.
module tb_axi4_wch_order_arbiter;

    localparam int NP = 2;
    localparam int LNP = 2;  // wide enough to express out-of-range ports 2 and 3
    localparam int DW = 32;
    localparam int UW = 2;
    localparam int SW = DW / 8;
    localparam int NG = 40;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    logic clk = 1'b0;
    logic rstn;
    logic grant_valid, grant_drop, grant_ready;
    logic [LNP-1:0] grant_port;
    logic [NP*DW-1:0] s_wdata;
    logic [NP*SW-1:0] s_wstrb;
    logic [NP*UW-1:0] s_wuser;
    logic [NP-1:0] s_wlast, s_wvalid, s_wready;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_wstrb;
    logic [UW-1:0] m_wuser;
    logic m_wlast, m_wvalid, m_wready;
    logic burst_done, burst_done_drop;
    logic [LNP-1:0] burst_done_port;
    logic [3:0] order_count;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    axi4_wch_order_arbiter #(
        .N_PORTS(NP), .LOG_N_PORTS(LNP), .C_AXI_DATA_WIDTH(DW), .C_AXI_USER_WIDTH(UW),
        .ORDER_DEPTH(8), .LOG_ORDER_DEPTH(3)
    ) dut (
        .axi4_aclk(clk), .axi4_arstn(rstn),
        .grant_valid(grant_valid), .grant_port(grant_port), .grant_drop(grant_drop),
        .grant_ready(grant_ready),
        .s_axi4_wdata(s_wdata), .s_axi4_wstrb(s_wstrb), .s_axi4_wuser(s_wuser),
        .s_axi4_wlast(s_wlast), .s_axi4_wvalid(s_wvalid), .s_axi4_wready(s_wready),
        .m_axi4_wdata(m_wdata), .m_axi4_wstrb(m_wstrb), .m_axi4_wuser(m_wuser),
        .m_axi4_wlast(m_wlast), .m_axi4_wvalid(m_wvalid), .m_axi4_wready(m_wready),
        .burst_done(burst_done), .burst_done_port(burst_done_port),
        .burst_done_drop(burst_done_drop), .order_count(order_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_port(input int p, input logic [DW-1:0] d, input logic [SW-1:0] s,
                              input logic [UW-1:0] u, input logic l, input logic v);
        s_wdata[p*DW +: DW] = d;
        s_wstrb[p*SW +: SW] = s;
        s_wuser[p*UW +: UW] = u;
        s_wlast[p]          = l;
        s_wvalid[p]         = v;
    endtask

    task automatic clear_inputs();
        grant_valid = 1'b0;
        grant_port  = '0;
        grant_drop  = 1'b0;
        m_wready    = 1'b0;
        s_wdata = '0; s_wstrb = '0; s_wuser = '0; s_wlast = '0; s_wvalid = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rstn = 1'b0;
        drive_port(0, 32'hdead_beef, 4'hf, 2'd3, 1'b1, 1'b1);
        m_wready = 1'b1;
        step();
        #4;
        compared++;
        if ({grant_ready, order_count} !== 5'b1_0000) begin
            mismatched++;
            $display("FAIL reset_fifo: got %0h want 10", {grant_ready, order_count});
        end
        compared++;
        if ({m_wvalid, m_wdata, m_wstrb, m_wuser, m_wlast} !== '0) begin
            mismatched++;
            $display("FAIL reset_master: got %0h want 0", {m_wvalid, m_wdata, m_wstrb, m_wlast});
        end
        compared++;
        if ({s_wready, burst_done, burst_done_port, burst_done_drop} !== '0) begin
            mismatched++;
            $display("FAIL reset_ready_done: got %0h want 0",
                     {s_wready, burst_done, burst_done_port, burst_done_drop});
        end
        rstn = 1'b1;
        step();
        #4;
        compared++;
        if ({s_wready, m_wvalid, grant_ready} !== 4'b0001) begin
            mismatched++;
            $display("FAIL reset_release: got %0b want 0001", {s_wready, m_wvalid, grant_ready});
        end
        clear_inputs();
        step();
    endtask

    task automatic test_single();
        logic [DW-1:0] d [4];
        for (int b = 0; b < 4; b++) d[b] = $urandom;
        grant_valid = 1'b1; grant_port = 2'd0; grant_drop = 1'b0; m_wready = 1'b1;
        drive_port(0, d[0], 4'd1, 2'd0, 1'b0, 1'b1);
        #4;
        compared++;
        if (m_wvalid !== 1'b0) begin
            mismatched++; $display("FAIL single_t0_valid: got %b want 0", m_wvalid);
        end
        step();
        grant_valid = 1'b0;
        #4;
        compared++;
        if ({order_count, s_wready[0], m_wvalid} !== 6'b0001_00) begin
            mismatched++;
            $display("FAIL single_t1: got %0h want 4", {order_count, s_wready[0], m_wvalid});
        end
        step();
        for (int b = 0; b < 4; b++) begin
            drive_port(0, d[b], 4'(b + 1), 2'(b), b == 3, 1'b1);
            #4;
            compared++;
            if ({m_wvalid, s_wready[0], m_wdata, m_wstrb, m_wuser, m_wlast} !==
                {2'b11, d[b], 4'(b + 1), 2'(b), b == 3}) begin
                mismatched++;
                $display("FAIL single_beat%0d: got %0h/%0b want %0h/%0b", b, m_wdata,
                         {m_wvalid, s_wready[0], m_wlast}, d[b], {2'b11, b == 3});
            end
            step();
        end
        drive_port(0, '0, '0, '0, 1'b0, 1'b0);
        #4;
        compared++;
        if ({burst_done, burst_done_port, burst_done_drop} !== 4'b1000) begin
            mismatched++;
            $display("FAIL single_done: got %0b want 1000",
                     {burst_done, burst_done_port, burst_done_drop});
        end
        step();
        #4;
        compared++;
        if (burst_done !== 1'b0) begin
            mismatched++; $display("FAIL single_done_width: got %b want 0", burst_done);
        end
        step();
    endtask

    task automatic test_order();
        logic [DW-1:0] d0, d1a, d1b;
        d0 = $urandom; d1a = $urandom; d1b = $urandom;
        m_wready = 1'b1;
        grant_valid = 1'b1; grant_port = 2'd1; grant_drop = 1'b0;
        drive_port(0, d0, 4'hf, 2'd0, 1'b1, 1'b1);
        #4;
        compared++;
        if (s_wready[0] !== 1'b0) begin
            mismatched++; $display("FAIL order_hold_c0: got %b want 0", s_wready[0]);
        end
        step();
        grant_port = 2'd0;
        step();
        grant_valid = 1'b0;
        drive_port(1, d1a, 4'hf, 2'd1, 1'b0, 1'b1);
        #4;
        compared++;
        if ({s_wready[0], m_wvalid, m_wdata} !== {2'b01, d1a}) begin
            mismatched++;
            $display("FAIL order_p1_beat0: got %0h/%b want %0h/0", m_wdata, s_wready[0], d1a);
        end
        step();
        drive_port(1, d1b, 4'hf, 2'd1, 1'b1, 1'b1);
        #4;
        compared++;
        if ({s_wready[0], m_wlast, m_wdata} !== {2'b01, d1b}) begin
            mismatched++;
            $display("FAIL order_p1_beat1: got %0h/%b want %0h/0", m_wdata, s_wready[0], d1b);
        end
        step();
        drive_port(1, '0, '0, '0, 1'b0, 1'b0);
        #4;
        compared++;
        if ({s_wready[0], m_wvalid, m_wdata, burst_done, burst_done_port} !==
            {2'b11, d0, 1'b1, 2'd1}) begin
            mismatched++;
            $display("FAIL order_p0_no_gap: got %0h/%b want %0h/111", m_wdata,
                     {s_wready[0], m_wvalid, burst_done, burst_done_port}, d0);
        end
        step();
        drive_port(0, '0, '0, '0, 1'b0, 1'b0);
        #4;
        compared++;
        if ({burst_done, burst_done_port, burst_done_drop} !== 4'b1000) begin
            mismatched++;
            $display("FAIL order_p0_done: got %0b want 1000",
                     {burst_done, burst_done_port, burst_done_drop});
        end
        step();
    endtask

    task automatic test_drop();
        m_wready = 1'b0;
        grant_valid = 1'b1; grant_port = 2'd1; grant_drop = 1'b1;
        step();
        grant_valid = 1'b0; grant_drop = 1'b0;
        step();
        for (int b = 0; b < 3; b++) begin
            drive_port(1, $urandom, 4'hf, 2'd2, b == 2, 1'b1);
            #4;
            compared++;
            if ({s_wready[1], m_wvalid, burst_done} !== 3'b100) begin
                mismatched++;
                $display("FAIL drop_beat%0d: got %0b want 100", b,
                         {s_wready[1], m_wvalid, burst_done});
            end
            step();
        end
        drive_port(1, '0, '0, '0, 1'b0, 1'b0);
        #4;
        compared++;
        if ({burst_done, burst_done_port, burst_done_drop} !== 4'b1011) begin
            mismatched++;
            $display("FAIL drop_done: got %0b want 1011",
                     {burst_done, burst_done_port, burst_done_drop});
        end
        step();
    endtask

    task automatic test_fill();
        int acc = 0;
        m_wready = 1'b0;
        drive_port(0, $urandom, 4'hf, 2'd0, 1'b1, 1'b1);
        grant_valid = 1'b1; grant_port = 2'd0; grant_drop = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #4;
            if (!grant_ready) break;
            acc++;
            step();
        end
        compared++;
        if (acc !== 9 || order_count !== 4'd8) begin
            mismatched++;
            $display("FAIL fill_full: got accepted=%0d count=%0d want 9/8", acc, order_count);
        end
        step();
        #4;
        compared++;
        if ({grant_ready, order_count} !== 5'b0_1000) begin
            mismatched++;
            $display("FAIL fill_ninth_refused: got %0h want 08", {grant_ready, order_count});
        end
        step();
        grant_valid = 1'b0;
        m_wready = 1'b1;
        #4;
        compared++;
        if ({m_wvalid, grant_ready} !== 2'b10) begin
            mismatched++; $display("FAIL fill_first_done: got %0b want 10", {m_wvalid, grant_ready});
        end
        step();
        #4;
        compared++;
        if ({grant_ready, order_count} !== 5'b1_0111) begin
            mismatched++;
            $display("FAIL fill_ready_back: got %0h want 17", {grant_ready, order_count});
        end
        for (int i = 0; i < 7; i++) step();
        #4;
        compared++;
        if (order_count !== 4'd0) begin
            mismatched++; $display("FAIL fill_drain: got %0d want 0", order_count);
        end
        step();
        drive_port(0, '0, '0, '0, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_bad_port();
        bit seen = 0;
        m_wready = 1'b1;
        grant_valid = 1'b1; grant_port = 2'd3; grant_drop = 1'b0;
        step();
        grant_valid = 1'b0; grant_port = 2'd0;
        for (int c = 0; c < 6; c++) begin
            #4;
            compared++;
            if ({s_wready, m_wvalid} !== 3'b000) begin
                mismatched++; $display("FAIL bad_port_idle: got %0b want 000", {s_wready, m_wvalid});
            end
            if (burst_done) begin
                seen = 1;
                break;
            end
            step();
        end
        compared++;
        if (!seen || {burst_done_port, burst_done_drop} !== 3'b111) begin
            mismatched++;
            $display("FAIL bad_port_done: got seen=%0b %0b want 1 111", seen,
                     {burst_done_port, burst_done_drop});
        end
        step();
        step();
    endtask

    task automatic test_reset_mid();
        m_wready = 1'b1;
        grant_valid = 1'b1; grant_port = 2'd0; grant_drop = 1'b0;
        drive_port(0, 32'h1111_0000, 4'hf, 2'd0, 1'b0, 1'b1);
        step();
        grant_port = 2'd1;
        step();
        grant_valid = 1'b0;
        step();
        drive_port(0, 32'h1111_0001, 4'hf, 2'd0, 1'b0, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        compared++;
        if ({m_wvalid, m_wdata, m_wstrb, m_wuser, m_wlast, s_wready} !== '0) begin
            mismatched++;
            $display("FAIL reset_mid_outputs: got %0h want 0", {m_wvalid, m_wdata, s_wready});
        end
        compared++;
        if ({grant_ready, order_count} !== 5'b1_0000) begin
            mismatched++;
            $display("FAIL reset_mid_fifo: got %0h want 10", {grant_ready, order_count});
        end
        step();
        #4;
        rstn = 1'b1;
        step();
        for (int b = 2; b < 5; b++) begin
            drive_port(0, 32'h1111_0000 + b, 4'hf, 2'd0, b == 3, 1'b1);
            #4;
            compared++;
            if ({s_wready[0], m_wvalid, burst_done} !== 3'b000) begin
                mismatched++;
                $display("FAIL reset_mid_ignored%0d: got %0b want 000", b,
                         {s_wready[0], m_wvalid, burst_done});
            end
            step();
        end
        clear_inputs();
        step();
    endtask

    task automatic test_random();
        logic [LNP-1:0] gp [NG];
        logic gd [NG];
        beat_t pq [NP][$];
        beat_t mq [$];
        logic [LNP:0] dq [$];
        logic pv [NP];
        beat_t bt, exp_b;
        logic [LNP:0] exp_d;
        int gi = 0;
        bit finished = 0;
        for (int g = 0; g < NG; g++) begin
            bit bad;
            int len;
            bad = ($urandom % 8 == 0);
            gp[g] = bad ? LNP'(2 + $urandom % 2) : LNP'($urandom % 2);
            gd[g] = ($urandom % 4 == 0);
            len = 1 + int'($urandom % 4);
            dq.push_back({gd[g] | bad, gp[g]});
            if (!bad) begin
                for (int b = 0; b < len; b++) begin
                    bt = '{d: $urandom, s: SW'($urandom), u: UW'($urandom), l: b == len - 1};
                    pq[gp[g]].push_back(bt);
                    if (!gd[g]) mq.push_back(bt);
                end
            end
        end
        for (int p = 0; p < NP; p++) pv[p] = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (gi < NG) begin
                grant_valid = ($urandom % 3 != 0);
                grant_port = gp[gi];
                grant_drop = gd[gi];
            end else begin
                grant_valid = 1'b0;
            end
            for (int p = 0; p < NP; p++) begin
                if (pq[p].size() > 0) begin
                    if (!pv[p]) pv[p] = ($urandom % 4 != 0);
                    drive_port(p, pq[p][0].d, pq[p][0].s, pq[p][0].u, pq[p][0].l, pv[p]);
                end else begin
                    pv[p] = 1'b0;
                    drive_port(p, '0, '0, '0, 1'b0, 1'b0);
                end
            end
            m_wready = ($urandom % 4 != 0);
            #4;
            if (grant_valid && grant_ready) gi++;
            for (int p = 0; p < NP; p++) begin
                if (s_wvalid[p] && s_wready[p]) begin
                    void'(pq[p].pop_front());
                    pv[p] = 1'b0;
                end
            end
            if (m_wvalid && m_wready) begin
                compared++;
                if (mq.size() == 0) begin
                    mismatched++; $display("FAIL rand_extra_beat: got %0h want none", m_wdata);
                end else begin
                    exp_b = mq.pop_front();
                    if ({m_wdata, m_wstrb, m_wuser, m_wlast} !== exp_b) begin
                        mismatched++;
                        $display("FAIL rand_beat: got %0h want %0h",
                                 {m_wdata, m_wstrb, m_wuser, m_wlast}, exp_b);
                    end
                end
            end
            if (burst_done) begin
                compared++;
                if (dq.size() == 0) begin
                    mismatched++; $display("FAIL rand_extra_done: got 1 want none");
                end else begin
                    exp_d = dq.pop_front();
                    if ({burst_done_drop, burst_done_port} !== exp_d) begin
                        mismatched++;
                        $display("FAIL rand_done: got %0b want %0b",
                                 {burst_done_drop, burst_done_port}, exp_d);
                    end
                end
            end
            if (gi == NG && mq.size() == 0 && dq.size() == 0 &&
                pq[0].size() == 0 && pq[1].size() == 0) begin
                finished = 1;
                break;
            end
            step();
        end
        compared++;
        if (!finished) begin
            mismatched++;
            $display("FAIL rand_timeout: got gi=%0d beats=%0d dones=%0d want %0d/0/0",
                     gi, mq.size(), dq.size(), NG);
        end
        step();
        clear_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_order();
        test_drop();
        test_fill();
        test_bad_port();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
